flag_ctrl: RTL

Condition-code register (CCR) controller for the execute stage. It consumes the ALU's per-operation flag result, holds the architectural {C,N,Z} flags, and returns them to the ALU's flag input. It also resolves conditional jumps against the committed flags and saves/restores flags across interrupt entry and RTI. It sits beside the ALU in ExecuteStage and closes the ALU flag loop.

---
 rtl/flag_pkg.sv | 28 ++
 rtl/flag_save_stack.sv | 46 ++++
 rtl/flag_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/flag_pkg.sv
// flag_pkg: shared ALU opcodes, CCR flag bit indices, branch types and controller state.
//   Opcodes are shared with the ALU.
//   FLAG_Z/FLAG_N/FLAG_C index the flag vector (bit0=Z, bit1=N, bit2=C).
package flag_pkg;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_DEC  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_NOP  = 4'b1000;
    localparam logic [3:0] OP_SETC = 4'b1001;
    localparam logic [3:0] OP_CLRC = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    localparam logic [1:0] BR_JMP = 2'b00;
    localparam logic [1:0] BR_JZ  = 2'b01;
    localparam logic [1:0] BR_JN  = 2'b10;
    localparam logic [1:0] BR_JC  = 2'b11;

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/flag_save_stack.sv
// flag_save_stack: DEPTH x W LIFO holding CCR snapshots across interrupt entry.
//   clk, rst  : clock, asynchronous active-high reset
//   push, pop : push din / pop top entry (ignored when full / empty; push wins)
//   din, dout : pushed value / current top-of-stack value
//   full, empty : occupancy flags
module flag_save_stack #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   cnt;
    logic [AW-1:0] wr;
    logic [AW-1:0] top;

    // Low pointer bits wrap modulo DEPTH; the extra count bit separates full from empty.
    assign wr    = cnt[AW-1:0];
    assign top   = wr - AW'(1);
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout  = mem[top];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (push && !full)
            cnt <= cnt + (AW+1)'(1);
        else if (pop && !empty)
            cnt <= cnt - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr] <= din;
    end
endmodule

// File: rtl/flag_ctrl.sv
// flag_ctrl: condition-code register controller closing the ALU flag loop in EX.
//   Optional save stack / rti restore enabled by defining FLAG_CTRL_SAVE_EN.
//   clk, rst            : clock, asynchronous active-high reset
//   ex_valid, ex_op     : ALU instruction in EX and its opcode
//   alu_flags           : ALU flag result for ex_op ({C,N,Z})
//   br_valid, br_type   : conditional jump in EX and its type
//   int_req, rti        : interrupt-entry and return-from-interrupt pulses
//   flags_out           : committed CCR, fed back to the ALU
//   br_taken            : combinational jump resolution from the committed CCR
//   hold                : CCR frozen after interrupt entry
//   save_full/save_empty: save stack occupancy
//   err                 : sticky protocol error
module flag_ctrl
    import flag_pkg::*;
#(
    parameter int FLAG_W     = 3,
    parameter int SAVE_DEPTH = 2,
    parameter int HOLD_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [3:0]        ex_op,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic              int_req,
    input  logic              rti,
    output logic [FLAG_W-1:0] flags_out,
    output logic              br_taken,
    output logic              hold,
    output logic              save_full,
    output logic              save_empty,
    output logic              err
);
    localparam logic [FLAG_W-1:0] Z_M = FLAG_W'(1) << FLAG_Z;
    localparam logic [FLAG_W-1:0] N_M = FLAG_W'(1) << FLAG_N;
    localparam logic [FLAG_W-1:0] C_M = FLAG_W'(1) << FLAG_C;

    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("flag_ctrl: HOLD_CYC must be 1..15");
    end
    if (SAVE_DEPTH < 1 || (SAVE_DEPTH & (SAVE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("flag_ctrl: SAVE_DEPTH must be a power of two");
    end

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [FLAG_W-1:0] ccr, ccr_n, sel;
    logic              err_n, run, full, empty;

`ifdef FLAG_CTRL_SAVE_EN
    logic              push, pop;
    logic [FLAG_W-1:0] pop_flags;

    // The snapshot pushed on interrupt entry is the pre-update CCR.
    assign push = run && int_req && !full;
    assign pop  = run && rti && !int_req && !empty;

    flag_save_stack #(.DEPTH(SAVE_DEPTH), .W(FLAG_W)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (ccr),
        .dout  (pop_flags),
        .full  (full),
        .empty (empty)
    );
`else
    assign full  = 1'b0;
    assign empty = 1'b1;
`endif

    always_comb begin
        run      = state == RUN;
        sel      = br_type == BR_JZ ? Z_M : br_type == BR_JN ? N_M : C_M;
        br_taken = br_valid && run && (br_type == BR_JMP || |(ccr & sel));
        state_n  = state;
        cnt_n    = cnt;
        ccr_n    = ccr;
        err_n    = err;
        if (run) begin
            if (ex_valid)
                ccr_n = ex_op == OP_NOP  ? ccr :
                        ex_op == OP_SETC ? ccr | C_M :
                        ex_op == OP_CLRC ? ccr & ~C_M : alu_flags;
            // Branch clear lands on top of the ALU result so it wins for the tested bit.
            if (br_taken && br_type != BR_JMP)
                ccr_n = ccr_n & ~sel;
`ifdef FLAG_CTRL_SAVE_EN
            if (rti && !int_req) begin
                ccr_n = empty ? ccr : pop_flags;
                err_n = err_n | empty;
            end
`endif
            if (int_req) begin
                ccr_n   = '0;
                state_n = HOLD;
                cnt_n   = 4'(HOLD_CYC - 1);
                err_n   = err_n | rti | full;
            end
        end else begin
            err_n   = err_n | int_req;
            state_n = cnt == 4'd0 ? RUN : HOLD;
            cnt_n   = cnt == 4'd0 ? cnt : cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            ccr   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ccr   <= ccr_n;
            err   <= err_n;
        end
    end

    assign flags_out  = ccr;
    assign hold       = state == HOLD;
    assign save_full  = full;
    assign save_empty = empty;
endmodule
